// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC burst write sequencer.
package rtc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_XFER, ST_DONE} state_e;

  localparam logic [7:0] RTC_XFER_CMD = 8'hF0;

  // Width able to hold every length from 0 to max_burst inclusive.
  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rtc_wdog.sv
// Fin watchdog: counts cycles while clr_i is low and pulses expire_o on the
// TIMEOUT_CYC-th consecutive uncleared cycle.
module rtc_wdog #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    cnt_d    = (clr_i || expire_o) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_burst_write.sv
// RTC register burst writer: captures up to MAX_BURST words, writes them to consecutive
// addresses, then issues the clock-transfer command. RTC_TIMEOUT_EN adds the fin watchdog.
module rtc_burst_write
  import rtc_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         ADDR_W    = 8,
  parameter int         MAX_BURST = 4,
  parameter logic [7:0] XFER_CMD  = RTC_XFER_CMD
`ifdef RTC_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYC = 1023
`endif
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        iniciar_i,
  input  logic [ADDR_W-1:0]           dir_i,
  input  logic [len_w(MAX_BURST)-1:0] len_i,
  input  logic [MAX_BURST*DATA_W-1:0] dato_i,
  input  logic                        fin_i,
  output logic [DATA_W-1:0]           data_out_o,
  output logic [ADDR_W-1:0]           dir_out_o,
  output logic                        escribe_o,
  output logic                        activa_o,
  output logic                        final_o,
  output logic                        error_o
);

  localparam int LEN_W = len_w(MAX_BURST);

  state_e                      state_q, state_d;
  logic [LEN_W-1:0]            idx_q, idx_d, len_q, len_d, len_clamped;
  logic [ADDR_W-1:0]           dir_q, dir_d;
  logic [MAX_BURST*DATA_W-1:0] dato_q, dato_d;
  logic                        accept, busy, expire;
  logic [DATA_W-1:0]           data_out_d;
  logic [ADDR_W-1:0]           dir_out_d;
  logic                        escribe_d, activa_d, final_d, error_d;

  assign accept      = (state_q == ST_IDLE) && iniciar_i;
  assign busy        = (state_q == ST_WRITE) || (state_q == ST_XFER);
  assign len_clamped = (int'(len_i) > MAX_BURST) ? LEN_W'(MAX_BURST) : len_i;

  // Outputs are computed from the state being entered, so they must see fresh captures.
  assign dir_d  = accept ? dir_i       : dir_q;
  assign len_d  = accept ? len_clamped : len_q;
  assign dato_d = accept ? dato_i      : dato_q;

`ifdef RTC_TIMEOUT_EN
  rtc_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (reset_i),
    .clr_i    (!busy || fin_i),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      dir_q      <= '0;
      dato_q     <= '0;
      data_out_o <= '0;
      dir_out_o  <= '0;
      escribe_o  <= 1'b0;
      activa_o   <= 1'b0;
      final_o    <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      dato_q     <= dato_d;
      data_out_o <= data_out_d;
      dir_out_o  <= dir_out_d;
      escribe_o  <= escribe_d;
      activa_o   <= activa_d;
      final_o    <= final_d;
      error_o    <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = '0;
          state_d = (len_clamped == '0) ? ST_XFER : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (fin_i) begin
          if (idx_q == len_q - LEN_W'(1)) state_d = ST_XFER;
          else                            idx_d   = idx_q + LEN_W'(1);
        end else if (expire) begin
          state_d = ST_DONE;
        end
      end
      ST_XFER: begin
        if (fin_i || expire) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_out_d = '0;
    dir_out_d  = '0;
    escribe_d  = 1'b0;
    activa_d   = 1'b0;
    final_d    = 1'b0;
    error_d    = expire;
    case (state_d)
      ST_WRITE: begin
        escribe_d  = 1'b1;
        activa_d   = 1'b1;
        dir_out_d  = dir_d + ADDR_W'(idx_d);
        data_out_d = dato_d[DATA_W*int'(idx_d) +: DATA_W];
      end
      ST_XFER: begin
        escribe_d  = 1'b1;
        activa_d   = 1'b1;
        dir_out_d  = ADDR_W'(XFER_CMD);
        data_out_d = DATA_W'(XFER_CMD);
      end
      ST_DONE: final_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_burst_write.sv
// Bench for rtc_burst_write: directed vector table, reset/timeout sequences, and
// randomized bursts checked against a transaction-level expected-write queue.
module tb_rtc_burst_write;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        iniciar_i;
  logic [7:0]  dir_i;
  logic [2:0]  len_i;
  logic [31:0] dato_i;
  logic        fin_i;
  logic [7:0]  data_out_o;
  logic [7:0]  dir_out_o;
  logic        escribe_o, activa_o, final_o, error_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_d[$];

  typedef struct {
    logic [7:0]  dir;
    logic [2:0]  len;
    logic [31:0] dato;
    int          n;
    logic [39:0] ea;
    logic [39:0] ed;
  } vec_t;

  vec_t vecs[5];

  always #5 clk_i = ~clk_i;

  rtc_burst_write #(
    .DATA_W(8), .ADDR_W(8), .MAX_BURST(4), .XFER_CMD(8'hF0)
`ifdef RTC_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .iniciar_i(iniciar_i), .dir_i(dir_i),
    .len_i(len_i), .dato_i(dato_i), .fin_i(fin_i), .data_out_o(data_out_o),
    .dir_out_o(dir_out_o), .escribe_o(escribe_o), .activa_o(activa_o),
    .final_o(final_o), .error_o(error_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_escribe"}, escribe_o, 0);
    check({nm, "_activa"}, activa_o, 0);
    check({nm, "_final"}, final_o, 0);
    check({nm, "_dir_out"}, dir_out_o, 0);
    check({nm, "_data_out"}, data_out_o, 0);
  endtask

  // Reference: clamp the length, then one write per word at wrapping consecutive addresses,
  // followed by the transfer command.
  task automatic model(input logic [7:0] d, input logic [2:0] l, input logic [31:0] w);
    int lc = (l > 3'd4) ? 4 : int'(l);
    for (int i = 0; i < lc; i++) begin
      exp_a.push_back(8'((int'(d) + i) % 256));
      exp_d.push_back(8'(w >> (8 * i)));
    end
    exp_a.push_back(8'hF0);
    exp_d.push_back(8'hF0);
  endtask

  // Called at a negedge with the DUT idle; plays the bus driver against the expected queue.
  task automatic run_txn(input logic [7:0] d, input logic [2:0] l, input logic [31:0] w);
    iniciar_i = 1'b1; dir_i = d; len_i = l; dato_i = w;
    @(negedge clk_i);
    dir_i = 8'($urandom); len_i = 3'($urandom); dato_i = $urandom;
    while (exp_a.size() > 0) begin
      int waits = $urandom_range(0, 3);
      for (int k = 0; k <= waits; k++) begin
        check("busy_escribe", escribe_o, 1);
        check("busy_activa", activa_o, 1);
        check("busy_final", final_o, 0);
        check("dir_out", dir_out_o, exp_a[0]);
        check("data_out", data_out_o, exp_d[0]);
        fin_i = (k == waits);
        iniciar_i = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk_i);
      end
      void'(exp_a.pop_front());
      void'(exp_d.pop_front());
    end
    check("done_final", final_o, 1);
    check("done_error", error_o, 0);
    check("done_activa", activa_o, 0);
    check("done_escribe", escribe_o, 0);
    iniciar_i = 1'b1; fin_i = 1'($urandom); dir_i = 8'($urandom); len_i = 3'd2;
    @(negedge clk_i);
    check_quiet("idle_after");
    iniciar_i = 1'b0; fin_i = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h02, 3'd3, 32'h00332211, 4, 40'h00_F0_04_03_02, 40'h00_F0_33_22_11};
    vecs[1] = '{8'h55, 3'd0, 32'hDEADBEEF, 1, 40'h00_00_00_00_F0, 40'h00_00_00_00_F0};
    vecs[2] = '{8'hFE, 3'd3, 32'h00CCBBAA, 4, 40'h00_F0_00_FF_FE, 40'h00_F0_CC_BB_AA};
    vecs[3] = '{8'h10, 3'd7, 32'h44332211, 5, 40'hF0_13_12_11_10, 40'hF0_44_33_22_11};
    vecs[4] = '{8'hFD, 3'd4, 32'h0D0C0B0A, 5, 40'hF0_00_FF_FE_FD, 40'hF0_0D_0C_0B_0A};

    reset_i = 1'b1; iniciar_i = 1'b0; dir_i = '0; len_i = '0; dato_i = '0; fin_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_quiet("reset");
    check("reset_error", error_o, 0);
    reset_i = 1'b0;
    fin_i = 1'b1;
    @(negedge clk_i);
    check_quiet("idle_fin");
    fin_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        exp_a.push_back(vecs[i].ea[j*8 +: 8]);
        exp_d.push_back(vecs[i].ed[j*8 +: 8]);
      end
      run_txn(vecs[i].dir, vecs[i].len, vecs[i].dato);
    end

    // Reset while the second word of a burst is on the bus.
    fin_i = 1'b0;
    iniciar_i = 1'b1; dir_i = 8'h20; len_i = 3'd4; dato_i = 32'h44332211;
    @(negedge clk_i);
    iniciar_i = 1'b0; fin_i = 1'b1;
    check("rst_pre_dir0", dir_out_o, 8'h20);
    @(negedge clk_i);
    fin_i = 1'b0;
    check("rst_pre_dir1", dir_out_o, 8'h21);
    check("rst_pre_data1", data_out_o, 8'h22);
    #2 reset_i = 1'b1;
    #1 check_quiet("rst_mid");
    @(negedge clk_i);
    reset_i = 1'b0;
    model(8'h40, 3'd2, 32'h0000BBAA);
    run_txn(8'h40, 3'd2, 32'h0000BBAA);

    // Driver never answers during a write.
    fin_i = 1'b0;
    iniciar_i = 1'b1; dir_i = 8'h30; len_i = 3'd2; dato_i = 32'h00005A5A;
    @(negedge clk_i);
    iniciar_i = 1'b0;
`ifdef RTC_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      check("to_escribe", escribe_o, 1);
      check("to_final", final_o, 0);
      @(negedge clk_i);
    end
    check("to_final_pulse", final_o, 1);
    check("to_error_pulse", error_o, 1);
    check("to_activa", activa_o, 0);
    @(negedge clk_i);
    check_quiet("to_idle");
    check("to_error_clear", error_o, 0);
`else
    for (int k = 0; k < 20; k++) begin
      check("hold_escribe", escribe_o, 1);
      check("hold_final", final_o, 0);
      check("hold_dir", dir_out_o, 8'h30);
      @(negedge clk_i);
    end
`endif
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);

    for (int t = 0; t < 60; t++) begin
      logic [7:0]  d;
      logic [2:0]  l;
      logic [31:0] w;
      d = 8'($urandom);
      l = 3'($urandom_range(0, 7));
      w = $urandom;
      model(d, l, w);
      run_txn(d, l, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
